// File: rtl/count_seq_pkg.sv
// Shared types and constants for the seconds-counter sequencer.
// The state enum is also exported on the sequencer's debug state port.
package count_seq_pkg;

    localparam int COUNT_W = 6;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // Presets above the terminal value are clamped rather than wrapped.
    function automatic logic [COUNT_W-1:0] sat_count(input logic [COUNT_W-1:0] value,
                                                     input logic [COUNT_W-1:0] limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running phase counter that divides clk down to one tick every TICK_DIV enabled cycles.
// The phase freezes while en is low, so a pause/resume keeps its position in the period.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset_sw,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] phase;

    always_ff @(posedge clk or posedge reset_sw) begin
        if (reset_sw) begin
            phase <= '0;
        end else if (clr) begin
            phase <= '0;
        end else if (en) begin
            phase <= (phase == LAST) ? '0 : phase + PRE_W'(1);
        end
    end

    // en is a registered state decode, so this has no path from any top-level input.
    assign tick = en && (phase == LAST);

endmodule

// File: rtl/count_sequencer.sv
// Run/pause/preset controller for the 0..MAX_COUNT seconds counter behind the seven-segment display.
// Commands are single-cycle pulses with priority load > stop > start; count steps on prescaler ticks.
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int MAX_COUNT = 59
) (
    input  logic               clk,
    input  logic               reset_sw,
    input  logic               start_pulse,
    input  logic               stop_pulse,
    input  logic               load_pulse,
    input  logic [COUNT_W-1:0] load_value,
    input  logic               dir_down,
    output logic [COUNT_W-1:0] count,
    output logic               tick,
    output logic               running,
    output logic               paused,
    output logic               expired,
    output seq_state_t         state
);

    localparam logic [COUNT_W-1:0] MAX_C = COUNT_W'(MAX_COUNT);

    seq_state_t         state_d;
    logic [COUNT_W-1:0] count_d;
    logic               dir;
    logic               dir_d;
    logic               presc_clr;
    logic               presc_en;

    assign presc_en = (state == RUN);

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset_sw(reset_sw),
        .en      (presc_en),
        .clr     (presc_clr),
        .tick    (tick)
    );

    always_comb begin
        state_d   = state;
        count_d   = count;
        dir_d     = dir;
        presc_clr = 1'b0;
        if (load_pulse) begin
            count_d   = sat_count(load_value, MAX_C);
            presc_clr = 1'b1;
            state_d   = IDLE;
        end else if (stop_pulse) begin
            // A stop that lands on a tick suppresses the step as well.
            if (state == RUN) begin
                state_d = PAUSE;
            end else if (state == DONE) begin
                state_d = IDLE;
            end
        end else if (start_pulse && (state == IDLE)) begin
            if (!(dir_down ? (count == '0) : (count == MAX_C))) begin
                state_d   = RUN;
                dir_d     = dir_down;
                presc_clr = 1'b1;
            end
        end else if (start_pulse && (state == PAUSE)) begin
            state_d = RUN;
        end else if (tick) begin
            if (dir == DIR_DOWN) begin
                count_d = (count == '0) ? '0 : count - COUNT_W'(1);
                if (count_d == '0) begin
                    state_d = DONE;
                end
            end else begin
                count_d = (count >= MAX_C) ? MAX_C : count + COUNT_W'(1);
                if (count_d == MAX_C) begin
                    state_d = DONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset_sw) begin
        if (reset_sw) begin
            state   <= IDLE;
            count   <= '0;
            dir     <= DIR_UP;
            running <= 1'b0;
            paused  <= 1'b0;
            expired <= 1'b0;
        end else begin
            state   <= state_d;
            count   <= count_d;
            dir     <= dir_d;
            running <= (state_d == RUN);
            paused  <= (state_d == PAUSE);
            expired <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer with TICK_DIV=4, MAX_COUNT=59.
// Expected counts are queued when a run is started and popped one cycle after each observed tick.
module tb_count_sequencer;
    import count_seq_pkg::*;

    localparam int TICK_DIV  = 4;
    localparam int MAX_COUNT = 59;

    logic       clk         = 1'b0;
    logic       reset_sw    = 1'b1;
    logic       start_pulse = 1'b0;
    logic       stop_pulse  = 1'b0;
    logic       load_pulse  = 1'b0;
    logic [5:0] load_value  = '0;
    logic       dir_down    = 1'b0;
    logic [5:0] count;
    logic       tick;
    logic       running;
    logic       paused;
    logic       expired;
    seq_state_t state;

    count_sequencer #(
        .TICK_DIV (TICK_DIV),
        .MAX_COUNT(MAX_COUNT)
    ) dut (
        .clk        (clk),
        .reset_sw   (reset_sw),
        .start_pulse(start_pulse),
        .stop_pulse (stop_pulse),
        .load_pulse (load_pulse),
        .load_value (load_value),
        .dir_down   (dir_down),
        .count      (count),
        .tick       (tick),
        .running    (running),
        .paused     (paused),
        .expired    (expired),
        .state      (state)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [5:0] exp_q[$];
    logic       sb_on = 1'b0;
    logic       tick_d = 1'b0;
    int         tick_seen = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Scoreboard: the cycle after a tick, count must equal the next queued value.
    always @(negedge clk) begin
        if (tick_d && sb_on) begin
            if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
            else check("sb_count", 32'(count), 32'(exp_q.pop_front()));
        end
        tick_d    <= tick;
        tick_seen <= tick_seen + int'(tick);
    end

    // Called at a negedge; the pulse is seen by the next posedge and the task returns one negedge later.
    task automatic cmd(input logic ld, input logic sp, input logic st,
                       input logic [5:0] val, input logic dn);
        load_pulse  = ld;
        stop_pulse  = sp;
        start_pulse = st;
        load_value  = val;
        dir_down    = dn;
        @(negedge clk);
        load_pulse  = 1'b0;
        stop_pulse  = 1'b0;
        start_pulse = 1'b0;
    endtask

    task automatic wait_tick(input string tag, input int exp_gap);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 20);
        check(tag, 32'(n), 32'(exp_gap));
    endtask

    task automatic check_status(input string tag, input seq_state_t s, input logic [5:0] c);
        check({tag, "_state"}, 32'(state), 32'(s));
        check({tag, "_count"}, 32'(count), 32'(c));
        check({tag, "_running"}, 32'(running), 32'(s == RUN));
        check({tag, "_paused"}, 32'(paused), 32'(s == PAUSE));
        check({tag, "_expired"}, 32'(expired), 32'(s == DONE));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] v;
        logic [5:0] exp_v;

        repeat (2) @(negedge clk);
        check_status("reset", IDLE, 6'd0);
        check("reset_tick", 32'(tick), 32'd0);
        reset_sw = 1'b0;
        @(negedge clk);

        // Down run from 5 to expiry.
        cmd(1, 0, 0, 6'd5, 0);
        check_status("load5", IDLE, 6'd5);
        sb_on = 1'b1;
        for (int i = 4; i >= 0; i--) exp_q.push_back(6'(i));
        cmd(0, 0, 1, 6'd0, 1);
        check_status("start_down", RUN, 6'd5);
        wait_tick("first_tick_gap", 3);
        for (int i = 0; i < 4; i++) wait_tick("down_tick_gap", 4);
        @(negedge clk);
        check_status("down_done", DONE, 6'd0);
        cmd(0, 1, 0, 6'd0, 0);
        check_status("ack_stop", IDLE, 6'd0);
        check("q_empty_down", 32'(exp_q.size()), 32'd0);

        // Up run from 57 to terminal; further start ignored.
        cmd(1, 0, 0, 6'd57, 0);
        exp_q.push_back(6'd58);
        exp_q.push_back(6'd59);
        cmd(0, 0, 1, 6'd0, 0);
        wait_tick("up_first_gap", 3);
        wait_tick("up_tick_gap", 4);
        @(negedge clk);
        check_status("up_done", DONE, 6'd59);
        cmd(0, 0, 1, 6'd0, 0);
        check_status("start_in_done", DONE, 6'd59);
        cmd(0, 1, 0, 6'd0, 0);
        check_status("up_ack", IDLE, 6'd59);

        // Pause after two RUN cycles, resume keeps the prescaler phase.
        cmd(1, 0, 0, 6'd20, 0);
        cmd(0, 0, 1, 6'd0, 0);
        @(negedge clk);
        cmd(0, 1, 0, 6'd0, 0);
        check_status("paused", PAUSE, 6'd20);
        begin
            int t0;
            t0 = tick_seen;
            repeat (10) @(negedge clk);
            check("pause_no_tick", 32'(tick_seen), 32'(t0));
        end
        check_status("pause_hold", PAUSE, 6'd20);
        exp_q.push_back(6'd21);
        cmd(0, 0, 1, 6'd0, 0);
        check_status("resumed", RUN, 6'd20);
        wait_tick("resume_gap", 1);
        @(negedge clk);
        @(negedge clk);
        sb_on = 1'b0;

        // Saturating load and coincident commands.
        cmd(1, 0, 0, 6'd63, 0);
        check_status("load63", IDLE, 6'd59);
        cmd(0, 0, 1, 6'd0, 1);
        check_status("start_from59", RUN, 6'd59);
        cmd(1, 1, 1, 6'd10, 0);
        check_status("load_stop_start", IDLE, 6'd10);
        for (int i = 0; i < 4; i++) begin
            v = 6'($urandom_range(0, 63));
            exp_v = (v > 6'(MAX_COUNT)) ? 6'(MAX_COUNT) : v;
            cmd(1, 0, 0, v, 0);
            check("rand_load", 32'(count), 32'(exp_v));
        end

        // Stop and load colliding with a tick.
        cmd(1, 0, 0, 6'd5, 0);
        sb_on = 1'b1;
        exp_q.push_back(6'd4);
        exp_q.push_back(6'd3);
        cmd(0, 0, 1, 6'd0, 1);
        wait_tick("c_first_gap", 3);
        wait_tick("c_gap", 4);
        @(negedge clk);
        @(negedge clk);
        sb_on = 1'b0;
        wait_tick("pre_stop_gap", 2);
        check("tick_at_3", 32'(count), 32'd3);
        cmd(0, 1, 0, 6'd0, 0);
        check_status("stop_on_tick", PAUSE, 6'd3);
        cmd(0, 0, 1, 6'd0, 0);
        wait_tick("after_wrap_gap", 3);
        cmd(1, 0, 0, 6'd40, 0);
        check_status("load_on_tick", IDLE, 6'd40);

        // Asynchronous reset mid-run.
        cmd(1, 0, 0, 6'd30, 0);
        cmd(0, 0, 1, 6'd0, 0);
        repeat (2) @(negedge clk);
        #2 reset_sw = 1'b1;
        #1;
        check_status("async_reset", IDLE, 6'd0);
        check("async_reset_tick", 32'(tick), 32'd0);
        @(negedge clk);
        reset_sw = 1'b0;
        cmd(0, 0, 1, 6'd0, 1);
        check_status("start_down_at0", IDLE, 6'd0);
        cmd(0, 0, 1, 6'd0, 0);
        check_status("start_up_at0", RUN, 6'd0);
        wait_tick("post_reset_gap", 3);
        @(negedge clk);
        check("post_reset_count", 32'(count), 32'd1);

        check("q_empty_end", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
